// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode sequencer for the 16-bit core: owns PC, IR and all datapath strobes.
// Latency ALU 4 / LI 3 / JMP,illegal 2 cycles; FETCH stalls indefinitely until imem_valid.
module alu_seq_ctrl #(
  parameter int              WIDTH    = 16,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [3:0]       rf_ra1,
  output logic [3:0]       rf_ra2,
  output logic [3:0]       rf_wa,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [WIDTH-1:0] imm_out,
  output logic [1:0]       alu_opcode,
  output logic             busy,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LI   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir, ir_nxt;
  logic            illegal_nxt;
  logic [3:0]      op;

  assign op = ir[15:12];

  // Register-file and ALU controls are pure IR decodes so they hold from DECODE through WB.
  assign rf_ra1     = ir[7:4];
  assign rf_ra2     = ir[3:0];
  assign rf_wa      = ir[11:8];
  assign alu_opcode = ir[13:12];
  assign imm_out    = WIDTH'(ir[7:0]);
  assign imem_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      illegal <= illegal_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    illegal_nxt = illegal;
    imem_req    = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        halted = (state == S_HALT);
        if (start) begin
          state_nxt   = S_FETCH;
          pc_nxt      = RESET_PC;
          illegal_nxt = 1'b0;
        end
      end

      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_nxt    = imem_rdata;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        if (op[3:2] == 2'b00) begin
          state_nxt = S_EXEC;
        end else if (op == OP_LI) begin
          state_nxt = S_WB;
        end else if (op == OP_JMP) begin
          pc_nxt    = PC_W'(ir[7:0]);
          state_nxt = S_FETCH;
        end else if (op == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          // Unknown opcodes flag and fall through as a NOP.
          illegal_nxt = 1'b1;
          state_nxt   = S_FETCH;
        end
      end

      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_WB;
      end

      S_WB: begin
        busy      = 1'b1;
        rf_we     = 1'b1;
        wb_sel    = (op == OP_LI);
        state_nxt = S_FETCH;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: instruction-level model expanded into per-cycle plans, plus directed literal checks.
module tb_alu_seq_ctrl;
  localparam int              WIDTH    = 16;
  localparam int              PC_W     = 8;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [15:0]      imem_rdata = '0;
  logic             imem_valid = 1'b0;
  logic [3:0]       rf_ra1, rf_ra2, rf_wa;
  logic             rf_we, wb_sel;
  logic [WIDTH-1:0] imm_out;
  logic [1:0]       alu_opcode;
  logic             busy, halted, illegal;

  alu_seq_ctrl #(.WIDTH(WIDTH), .PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we), .wb_sel(wb_sel),
    .imm_out(imm_out), .alu_opcode(alu_opcode), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory responder with programmable wait states.
  logic [15:0] mem [256];
  int wait_lo = 0, wait_hi = 0, wcnt = 0;
  bit junk_en = 0, fetching = 0;

  always @(negedge clk) begin
    #1;
    if (imem_req) begin
      if (!fetching) begin
        fetching = 1;
        wcnt = $urandom_range(wait_hi, wait_lo);
      end
      if (wcnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem[imem_addr];
        fetching = 0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        wcnt--;
      end
    end else begin
      fetching = 0;
      imem_valid = junk_en ? 1'($urandom_range(1, 0)) : 1'b0;
      imem_rdata = 16'($urandom);
    end
  end

  // Model: each fetched instruction expands into a list of post-fetch cycles (act: 0 none, 1 jump, 2 halt, 3 illegal).
  typedef struct {
    bit we;
    bit wbs;
    int act;
  } step_t;

  step_t           q[$];
  step_t           cur;
  bit              m_run = 0, m_halt = 0, m_ill = 0;
  logic [PC_W-1:0] m_pc = RESET_PC;
  logic [15:0]     m_ir = '0;

  task automatic push(bit we, bit wbs, int act);
    step_t s;
    s.we = we; s.wbs = wbs; s.act = act;
    q.push_back(s);
  endtask

  task automatic plan(logic [3:0] op);
    if (op <= 4'h3) begin push(0, 0, 0); push(0, 0, 0); push(1, 0, 0); end
    else if (op == 4'h4) begin push(0, 0, 0); push(1, 1, 0); end
    else if (op == 4'h5) push(0, 0, 1);
    else if (op == 4'hF) push(0, 0, 2);
    else push(0, 0, 3);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_halt = 0; m_ill = 0; m_pc = RESET_PC; m_ir = '0;
      q.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_halt = 0; m_ill = 0; m_pc = RESET_PC;
      end
    end else if (q.size() == 0) begin
      if (imem_valid) begin
        m_ir = imem_rdata;
        m_pc = PC_W'(m_pc + 1);
        plan(m_ir[15:12]);
      end
    end else begin
      cur = q.pop_front();
      case (cur.act)
        1: m_pc = PC_W'(m_ir[7:0]);
        2: begin m_run = 0; m_halt = 1; end
        3: m_ill = 1;
        default: ;
      endcase
    end
  end

  bit chk_en = 0;
  bit e_fetch, e_we, e_wbs;

  always @(negedge clk) begin
    if (chk_en) begin
      e_fetch = m_run && (q.size() == 0);
      e_we = 0; e_wbs = 0;
      if (m_run && q.size() != 0) begin
        e_we = q[0].we; e_wbs = q[0].wbs;
      end
      chk("imem_req", imem_req, e_fetch);
      chk("imem_addr", imem_addr, m_pc);
      chk("busy", busy, m_run);
      chk("halted", halted, m_halt);
      chk("illegal", illegal, m_ill);
      chk("rf_we", rf_we, e_we);
      chk("wb_sel", wb_sel, e_wbs);
      chk("rf_ra1", rf_ra1, m_ir[7:4]);
      chk("rf_ra2", rf_ra2, m_ir[3:0]);
      chk("rf_wa", rf_wa, m_ir[11:8]);
      chk("alu_opcode", alu_opcode, m_ir[13:12]);
      chk("imm_out", imm_out, {8'h00, m_ir[7:0]});
    end
  end

  // Called right after a negedge; returns at negedge+1 of the first FETCH cycle.
  task automatic start_pulse();
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_halt(int lim);
    int n = 0;
    while (!halted && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  function automatic logic [15:0] rand_instr();
    int r = $urandom_range(15, 0);
    logic [3:0] op;
    if (r <= 6) op = 4'(r % 4);
    else if (r <= 8) op = 4'h4;
    else if (r <= 10) op = 4'h5;
    else if (r <= 13) op = 4'($urandom_range(14, 6));
    else if (r == 14) op = 4'hF;
    else op = 4'h1;
    return {op, 12'($urandom)};
  endfunction

  initial begin
    foreach (mem[i]) mem[i] = 16'hF000;
    repeat (2) @(negedge clk);
    chk_en = 1;
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_req", imem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_imm", imm_out, 16'h0000);

    // LI r3,5 with no wait states, then HALT.
    mem[0] = 16'h4305; mem[1] = 16'hF000;
    start_pulse();
    chk("li_c1_req", imem_req, 1);
    chk("li_c1_addr", imem_addr, 8'h00);
    @(negedge clk);
    chk("li_c2_addr", imem_addr, 8'h01);
    chk("li_c2_we", rf_we, 0);
    @(negedge clk);
    chk("li_wb_we", rf_we, 1);
    chk("li_wb_wa", rf_wa, 4'h3);
    chk("li_wb_sel", wb_sel, 1);
    chk("li_wb_imm", imm_out, 16'h0005);
    chk("li_model_pc", m_pc, 8'h01);
    @(negedge clk);
    chk("li_c4_we", rf_we, 0);
    chk("li_c4_addr", imem_addr, 8'h01);
    wait_halt(10);
    chk("halt_busy", busy, 0);

    // SUB r3,r1,r2 with 2 wait states; start is held during the busy cycles.
    wait_lo = 2; wait_hi = 2;
    mem[0] = 16'h1312;
    start_pulse();
    chk("sub_c1_req", imem_req, 1);
    @(negedge clk);
    #1 start = 1'b1;
    chk("sub_c2_req", imem_req, 1);
    @(negedge clk);
    chk("sub_c3_req", imem_req, 1);
    @(negedge clk);
    chk("sub_c4_req", imem_req, 0);
    @(negedge clk);
    chk("sub_exec_op", alu_opcode, 2'b01);
    chk("sub_exec_ra1", rf_ra1, 4'h1);
    chk("sub_exec_ra2", rf_ra2, 4'h2);
    chk("sub_exec_we", rf_we, 0);
    @(negedge clk);
    #1 start = 1'b0;
    chk("sub_wb_we", rf_we, 1);
    chk("sub_wb_sel", wb_sel, 0);
    chk("sub_wb_wa", rf_wa, 4'h3);
    @(negedge clk);
    chk("sub_c7_req", imem_req, 1);
    chk("sub_c7_addr", imem_addr, 8'h01);
    wait_halt(20);

    // JMP 0xFE, two LIs at 0xFE/0xFF, PC wraps to 0.
    wait_lo = 0; wait_hi = 0;
    mem[0] = 16'h50FE; mem[8'hFE] = 16'h4101; mem[8'hFF] = 16'h4202;
    start_pulse();
    @(negedge clk);
    chk("jmp_dec_we", rf_we, 0);
    @(negedge clk);
    chk("jmp_tgt_addr", imem_addr, 8'hFE);
    chk("jmp_tgt_we", rf_we, 0);
    @(negedge clk);
    @(negedge clk);
    chk("jmp_li1_wa", rf_wa, 4'h1);
    chk("jmp_li1_we", rf_we, 1);
    @(negedge clk);
    chk("jmp_ff_addr", imem_addr, 8'hFF);
    @(negedge clk);
    chk("jmp_wrap_addr", imem_addr, 8'h00);
    chk("jmp_wrap_model", m_pc, 8'h00);
    do_reset();

    // Illegal opcode, then HALT, then restart clears the flag.
    mem[0] = 16'h7123; mem[1] = 16'hF000;
    start_pulse();
    @(negedge clk);
    chk("ill_dec_flag", illegal, 0);
    @(negedge clk);
    chk("ill_flag", illegal, 1);
    chk("ill_next_addr", imem_addr, 8'h01);
    chk("ill_we", rf_we, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ill_halted", halted, 1);
    chk("ill_halt_busy", busy, 0);
    chk("ill_sticky", illegal, 1);
    start_pulse();
    chk("restart_ill", illegal, 0);
    chk("restart_addr", imem_addr, 8'h00);
    do_reset();

    // Reset asserted during EXEC of an ADD.
    mem[0] = 16'h0312;
    start_pulse();
    @(negedge clk);
    @(negedge clk);
    chk("rexec_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rexec_busy0", busy, 0);
    chk("rexec_addr", imem_addr, 8'h00);
    chk("rexec_wa", rf_wa, 4'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rexec_we", rf_we, 0);
    end
    #1 rst = 1'b0;

    // Randomized phase against the model.
    junk_en = 1; wait_lo = 0; wait_hi = 3;
    foreach (mem[i]) mem[i] = rand_instr();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      start = ($urandom_range(7, 0) == 0);
      rst = ($urandom_range(399, 0) == 0);
    end
    #1 rst = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
